// File: rtl/nv_ram_rwsp_param_if.sv
`default_nettype none
// ============================================================================
// Module      : nv_ram_rwsp_param_if
// Description : Read/write/output-stage bus for nv_ram_rwsp_param.
// Revision    : 1.0 - initial release
// ============================================================================
interface nv_ram_rwsp_param_if #(
    parameter int AW    = 8,
    parameter int WIDTH = 514
);
    logic [AW-1:0]    ra;
    logic             re;
    logic             ore;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic [AW-1:0]    wa;
    logic             we;
    logic [WIDTH-1:0] di;
    logic             init_busy;
    logic             addr_err;
    logic [31:0]      pwrbus_ram_pd;

    modport master (
        output ra, re, ore, wa, we, di, pwrbus_ram_pd,
        input  dout, dout_vld, init_busy, addr_err
    );

    modport slave (
        input  ra, re, ore, wa, we, di, pwrbus_ram_pd,
        output dout, dout_vld, init_busy, addr_err
    );
endinterface
`default_nettype wire

// File: rtl/nv_ram_rwsp_param.sv
`default_nettype none
// ============================================================================
// Module      : nv_ram_rwsp_param
// Description : Self-clearing 1W/1R register-file RAM with registered read
//               address, gated output register and read-valid tracking.
//               Optional write-to-read forwarding: NV_RAM_RWSP_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nv_ram_rwsp_param #(
    parameter int DEPTH = 160,
    parameter int WIDTH = 514,
    parameter int AW    = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    nv_ram_rwsp_param_if.slave   bus
);

    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    ra_q;
    logic             rd_pend_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_vld_q;
    logic             addr_err_q;

    logic             is_ready;
    logic             wa_ok;
    logic             ra_ok;
    logic             rdq_ok;
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_wd;
    logic [WIDTH-1:0] dout_ram;
    logic [WIDTH-1:0] dout_nxt;
    logic             pwrbus_unused;

    // ------------------------------------------------------------------
    // Clear-sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign is_ready = (state_q == ST_READY);

    // ------------------------------------------------------------------
    // Address range qualification
    // ------------------------------------------------------------------
    assign wa_ok  = ({1'b0, bus.wa} < DEPTH_EXT);
    assign ra_ok  = ({1'b0, bus.ra} < DEPTH_EXT);
    assign rdq_ok = ({1'b0, ra_q}   < DEPTH_EXT);

    // ------------------------------------------------------------------
    // Single array write port, shared by the sweep and the client
    // ------------------------------------------------------------------
    always_comb begin
        mem_we = 1'b0;
        mem_wa = bus.wa;
        mem_wd = bus.di;
        if (!is_ready) begin
            mem_we = 1'b1;
            mem_wa = cnt_q;
            mem_wd = '0;
        end else if (bus.we && wa_ok) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign dout_ram = rdq_ok ? mem_q[ra_q] : '0;

`ifdef NV_RAM_RWSP_BYPASS_EN
    logic fwd_hit;
    // Forward the in-flight write so dout sees it on the same edge it lands.
    assign fwd_hit  = bus.we && wa_ok && (bus.wa == ra_q);
    assign dout_nxt = fwd_hit ? bus.di : dout_ram;
`else
    assign dout_nxt = dout_ram;
`endif

    // ------------------------------------------------------------------
    // Read address, output stage and error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ra_q       <= '0;
            rd_pend_q  <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= is_ready && ((bus.we && !wa_ok) || (bus.re && !ra_ok));
            if (is_ready) begin
                if (bus.re) begin
                    ra_q <= bus.ra;
                end
                rd_pend_q <= bus.re;
                if (bus.ore) begin
                    dout_q     <= dout_nxt;
                    dout_vld_q <= rd_pend_q;
                end
            end
        end
    end

    assign bus.dout      = dout_q;
    assign bus.dout_vld  = dout_vld_q;
    assign bus.init_busy = !is_ready;
    assign bus.addr_err  = addr_err_q;

    // Power-bus control is accepted for library compatibility only.
    assign pwrbus_unused = ^bus.pwrbus_ram_pd;

endmodule
`default_nettype wire

// File: tb/tb_nv_ram_rwsp_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_nv_ram_rwsp_param
// Description : Directed self-checking bench for nv_ram_rwsp_param.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nv_ram_rwsp_param;

    localparam int DEPTH = 160;
    localparam int WIDTH = 514;
    localparam int AW    = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    nv_ram_rwsp_param_if #(.AW(AW), .WIDTH(WIDTH)) bus ();

    nv_ram_rwsp_param #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
        bus.we = 1'b1;
        bus.wa = addr;
        bus.di = data;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] addr, output logic [WIDTH-1:0] data,
                      output logic vld);
        bus.re  = 1'b1;
        bus.ra  = addr;
        bus.ore = 1'b1;
        tick();
        bus.re  = 1'b0;
        tick();
        data = bus.dout;
        vld  = bus.dout_vld;
    endtask

    task automatic sweep_len(output int n);
        n = 0;
        while (bus.init_busy && n < 1000) begin
            tick();
            n++;
        end
    endtask

    logic [WIDTH-1:0] rdata;
    logic             rvld;
    logic [WIDTH-1:0] coll_exp;
    int               n;

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        rst               = 1'b1;
        bus.ra            = '0;
        bus.re            = 1'b0;
        bus.ore           = 1'b0;
        bus.wa            = '0;
        bus.we            = 1'b0;
        bus.di            = '0;
        bus.pwrbus_ram_pd = 32'h0;
        tick();
        tick();

        // Reset state
        chk("rst_init_busy", WIDTH'(bus.init_busy), WIDTH'(1));
        chk("rst_dout",      bus.dout,              '0);
        chk("rst_dout_vld",  WIDTH'(bus.dout_vld),  '0);
        chk("rst_addr_err",  WIDTH'(bus.addr_err),  '0);
        rst = 1'b0;
        sweep_len(n);
        chk("sweep_len", WIDTH'(n), WIDTH'(160));

        // Basic read: 2-cycle latency, valid drops after re goes low
        wr(8'd7, WIDTH'(12'h2A5));
        bus.re  = 1'b1;
        bus.ra  = 8'd7;
        bus.ore = 1'b1;
        tick();
        bus.re  = 1'b0;
        tick();
        chk("basic_dout", bus.dout,             WIDTH'(12'h2A5));
        chk("basic_vld",  WIDTH'(bus.dout_vld), WIDTH'(1));
        tick();
        chk("basic_vld_drop", WIDTH'(bus.dout_vld), '0);

        // Output stall with an intervening write to the pending address
        wr(8'd3, WIDTH'(8'h11));
        bus.ore = 1'b0;
        bus.re  = 1'b1;
        bus.ra  = 8'd3;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.we = 1'b1;
                bus.wa = 8'd3;
                bus.di = WIDTH'(8'h22);
            end else begin
                bus.we = 1'b0;
            end
            tick();
        end
        bus.we = 1'b0;
        chk("stall_hold", bus.dout, WIDTH'(12'h2A5));
        bus.ore = 1'b1;
        tick();
        bus.re = 1'b0;
        chk("stall_dout", bus.dout,             WIDTH'(8'h22));
        chk("stall_vld",  WIDTH'(bus.dout_vld), WIDTH'(1));

        // Write/output collision on the latched read address
        wr(8'd5, WIDTH'(8'hAA));
        bus.ore = 1'b0;
        bus.re  = 1'b1;
        bus.ra  = 8'd5;
        tick();
        bus.re  = 1'b0;
        bus.we  = 1'b1;
        bus.wa  = 8'd5;
        bus.di  = WIDTH'(8'h55);
        bus.ore = 1'b1;
        tick();
        bus.we  = 1'b0;
`ifdef NV_RAM_RWSP_BYPASS_EN
        coll_exp = WIDTH'(8'h55);
`else
        coll_exp = WIDTH'(8'hAA);
`endif
        chk("coll_dout", bus.dout, coll_exp);
        rd(8'd5, rdata, rvld);
        chk("coll_reread", rdata, WIDTH'(8'h55));

        // Out-of-range write then read
        wr(8'd200, {WIDTH{1'b1}});
        chk("oor_wr_err", WIDTH'(bus.addr_err), WIDTH'(1));
        tick();
        chk("oor_wr_err_clr", WIDTH'(bus.addr_err), '0);
        bus.re  = 1'b1;
        bus.ra  = 8'd170;
        bus.ore = 1'b1;
        tick();
        bus.re  = 1'b0;
        chk("oor_rd_err", WIDTH'(bus.addr_err), WIDTH'(1));
        tick();
        chk("oor_rd_dout",    bus.dout,             '0);
        chk("oor_rd_vld",     WIDTH'(bus.dout_vld), WIDTH'(1));
        chk("oor_rd_err_clr", WIDTH'(bus.addr_err), '0);
        rd(8'd7, rdata, rvld);
        chk("oor_keep7", rdata, WIDTH'(12'h2A5));
        rd(8'd40, rdata, rvld);
        chk("oor_keep40", rdata, '0);
        rd(8'd72, rdata, rvld);
        chk("oor_keep72", rdata, '0);

        // Reset clear of a preloaded array
        wr(8'd0,   WIDTH'(16'hBEEF));
        wr(8'd80,  WIDTH'(16'hCAFE));
        wr(8'd159, WIDTH'(16'hF00D));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep_len(n);
        chk("clr_sweep_len", WIDTH'(n), WIDTH'(160));
        rd(8'd0, rdata, rvld);
        chk("clr_m0", rdata, '0);
        chk("clr_m0_vld", WIDTH'(rvld), WIDTH'(1));
        rd(8'd80, rdata, rvld);
        chk("clr_m80", rdata, '0);
        rd(8'd159, rdata, rvld);
        chk("clr_m159", rdata, '0);
        chk("clr_m159_vld", WIDTH'(rvld), WIDTH'(1));

        // Reset mid-sweep with client traffic during INIT
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        bus.we  = 1'b1;
        bus.wa  = 8'd10;
        bus.di  = {WIDTH{1'b1}};
        bus.re  = 1'b1;
        bus.ra  = 8'd10;
        bus.ore = 1'b1;
        for (int i = 0; i < 90; i++) begin
            tick();
        end
        chk("mid_busy", WIDTH'(bus.init_busy), WIDTH'(1));
        chk("mid_dout", bus.dout,              '0);
        chk("mid_vld",  WIDTH'(bus.dout_vld),  '0);
        chk("mid_err",  WIDTH'(bus.addr_err),  '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_busy_rst", WIDTH'(bus.init_busy), WIDTH'(1));
        sweep_len(n);
        bus.we = 1'b0;
        bus.re = 1'b0;
        chk("mid_sweep_len", WIDTH'(n), WIDTH'(160));
        rd(8'd10, rdata, rvld);
        chk("mid_m10", rdata, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
